// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 16-bit five-stage pipeline.
// Takes the EX/MEM address and store data, runs a request/done handshake with a
// variable-latency data memory, and stalls the pipeline until each access
// completes. Load data goes back to MEM/WB in the completion cycle.
// Optional build macro MEM_WDOG_EN adds a BUSY watchdog that aborts an access
// after MEM_TIMEOUT cycles and raises a sticky timeout error.
module mem_stage #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [ADDR_W-1:0] ALURes,
   input  logic [DATA_W-1:0] writeData,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   output logic [DATA_W-1:0] readData,
   output logic              stall,
   output logic              err
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t            r_state;
   logic              r_req;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;

   logic w_memOp;
   logic w_access;
   logic w_misalign;
   logic w_busy;
   logic w_done;
   logic w_timeout;
   logic w_errTo;

   // A memory instruction with an odd byte address is rejected, never issued.
   assign w_memOp    = valid & (memRead | memWrite);
   assign w_access   = w_memOp & ~ALURes[0];
   assign w_misalign = w_memOp & ALURes[0];
   assign w_busy     = (r_state == BUSY);
   assign w_done     = w_busy & mem_done;

`ifdef MEM_WDOG_EN
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_errTo;

   // The access is abandoned in the BUSY cycle that would bring the count to
   // MEM_TIMEOUT, so mem_req is high for exactly MEM_TIMEOUT cycles.
   assign w_timeout = w_busy & ~mem_done & (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
   assign w_errTo   = r_errTo;

   // Watchdog: count BUSY cycles without completion; timeout error stays until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_errTo <= 1'b0;
      end else begin
         if (!w_busy) begin
            r_cnt <= '0;
         end else if (!mem_done) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_timeout) begin
            r_errTo <= 1'b1;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_errTo   = 1'b0;
`endif

   // Access sequencer: latch the request on issue, hold it stable while BUSY,
   // capture load data on completion. A store wins when both read and write are set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  r_addr  <= ALURes;
                  r_wdata <= writeData;
                  r_wr    <= memWrite;
                  r_req   <= 1'b1;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (mem_done) begin
                  if (!r_wr) begin
                     r_rdata <= mem_rdata;
                  end
                  r_req   <= 1'b0;
                  r_state <= IDLE;
               end else if (w_timeout) begin
                  r_req   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign mem_req   = r_req;
   assign mem_wr    = r_wr;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

   // Stall on the issue cycle and every BUSY cycle until completion or timeout;
   // the completion cycle itself lets the pipeline advance.
   assign stall    = ~rst & ((~w_busy & w_access) | (w_busy & ~mem_done & ~w_timeout));
   assign err      = ~rst & (w_misalign | w_errTo);
   assign readData = rst ? '0 : ((w_done & ~r_wr) ? mem_rdata : r_rdata);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized instruction stream for
// mem_stage, checked against a transaction-level model of the memory stage.
// Build with MEM_WDOG_EN defined to exercise the watchdog (timeout 4).
module tb_mem_stage;

   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic        valid;
   logic        memRead;
   logic        memWrite;
   logic [15:0] ALURes;
   logic [15:0] writeData;
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_done;
   logic [15:0] readData;
   logic        stall;
   logic        err;

   int compared;
   int mismatched;

   // Model of the stage: one outstanding transaction, last load value, sticky timeout.
   bit          mPending;
   logic [15:0] mAddr;
   logic [15:0] mWdata;
   bit          mIsStore;
   logic [15:0] mLastLoad;
   bit          mTimedOut;
   int          mBusyCycles;

   mem_stage #(
      .ADDR_W      (16),
      .DATA_W      (16),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .ALURes    (ALURes),
      .writeData (writeData),
      .mem_req   (mem_req),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_done  (mem_done),
      .readData  (readData),
      .stall     (stall),
      .err       (err)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void modelReset();
      mPending    = 1'b0;
      mAddr       = 16'h0;
      mWdata      = 16'h0;
      mIsStore    = 1'b0;
      mLastLoad   = 16'h0;
      mTimedOut   = 1'b0;
      mBusyCycles = 0;
   endfunction

   function automatic bit modelTimesOut(input bit done);
`ifdef MEM_WDOG_EN
      return mPending && !done && (mBusyCycles == TO - 1);
`else
      return 1'b0;
`endif
   endfunction

   // One pipeline cycle: drive EX/MEM contents and memory response, check
   // outputs mid-cycle, then advance the model across the clock edge.
   task automatic applyStimulus(input bit v, input bit rd, input bit wr,
                                input logic [15:0] addr, input logic [15:0] wd,
                                input bit done, input logic [15:0] rdata);
      bit          isMem, wantAccess, badAddr, expStall, expErr, tmo;
      logic [15:0] expRead;
      valid     = v;
      memRead   = rd;
      memWrite  = wr;
      ALURes    = addr;
      writeData = wd;
      mem_done  = done;
      mem_rdata = rdata;
      isMem      = v && (rd || wr);
      wantAccess = isMem && (addr % 2 == 0);
      badAddr    = isMem && (addr % 2 == 1);
      tmo        = modelTimesOut(done);
      expStall   = mPending ? (!done && !tmo) : wantAccess;
      expErr     = badAddr || mTimedOut;
      expRead    = (mPending && done && !mIsStore) ? rdata : mLastLoad;
      @(negedge clk);
      checkOutput("stall", {15'h0, stall}, {15'h0, expStall});
      checkOutput("err", {15'h0, err}, {15'h0, expErr});
      checkOutput("readData", readData, expRead);
      checkOutput("mem_req", {15'h0, mem_req}, {15'h0, mPending});
      if (mPending) begin
         checkOutput("mem_addr", mem_addr, mAddr);
         checkOutput("mem_wr", {15'h0, mem_wr}, {15'h0, mIsStore});
         if (mIsStore) checkOutput("mem_wdata", mem_wdata, mWdata);
      end
      @(posedge clk);
      if (!mPending) begin
         if (wantAccess) begin
            mPending    = 1'b1;
            mAddr       = addr;
            mWdata      = wd;
            mIsStore    = wr;
            mBusyCycles = 0;
         end
      end else if (done) begin
         if (!mIsStore) mLastLoad = rdata;
         mPending = 1'b0;
      end else if (tmo) begin
         mPending  = 1'b0;
         mTimedOut = 1'b1;
      end else begin
         mBusyCycles++;
      end
      #1;
   endtask

   // Full access: issue cycle, some wait cycles, then the completion cycle.
   task automatic doAccess(input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wd, input int waits, input logic [15:0] rdata);
      applyStimulus(1'b1, rd, wr, addr, wd, 1'b0, 16'h0);
      for (int i = 0; i < waits; i++) begin
         applyStimulus(1'b1, rd, wr, addr, wd, 1'b0, 16'($urandom));
      end
      applyStimulus(1'b1, rd, wr, addr, wd, 1'b1, rdata);
   endtask

   // Assert reset mid-cycle and check the immediate effect, then release it.
   task automatic midCycleReset();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_mem_req", {15'h0, mem_req}, 16'h0);
      checkOutput("rst_stall", {15'h0, stall}, 16'h0);
      checkOutput("rst_err", {15'h0, err}, 16'h0);
      checkOutput("rst_readData", readData, 16'h0);
      checkOutput("rst_mem_addr", mem_addr, 16'h0);
      mem_done  = 1'b1;
      mem_rdata = 16'hDEAD;
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      modelReset();
      rst       = 1'b1;
      valid     = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      ALURes    = 16'h0;
      writeData = 16'h0;
      mem_done  = 1'b0;
      mem_rdata = 16'h0;
      #2;
      checkOutput("reset_mem_req", {15'h0, mem_req}, 16'h0);
      checkOutput("reset_stall", {15'h0, stall}, 16'h0);
      checkOutput("reset_readData", readData, 16'h0);
      checkOutput("reset_mem_wdata", mem_wdata, 16'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset during a pending load");
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0);
      midCycleReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h7777);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

      $display("[TB] zero-wait load");
      doAccess(1'b1, 1'b0, 16'h0010, 16'h0, 0, 16'hBEEF);

      $display("[TB] wait-state store");
      doAccess(1'b0, 1'b1, 16'h00A2, 16'h1234, 5, 16'h0);

      $display("[TB] back-to-back load then store");
      doAccess(1'b1, 1'b0, 16'h0002, 16'h0, 1, 16'h5555);
      doAccess(1'b0, 1'b1, 16'h0004, 16'hCAFE, 2, 16'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

      $display("[TB] misaligned load, bubble, read+write counts as write");
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h0);
      doAccess(1'b1, 1'b1, 16'h0030, 16'hA5A5, 1, 16'h1111);

      $display("[TB] randomized instruction stream");
      for (int n = 0; n < 200; n++) begin
         int          kind;
         logic [15:0] a;
         logic [15:0] d;
         kind = $urandom_range(0, 5);
         a    = 16'($urandom) & 16'hFFFE;
         d    = 16'($urandom);
         case (kind)
            0: applyStimulus(1'b0, 1'($urandom), 1'($urandom), a, d, 1'($urandom), 16'($urandom));
            1: applyStimulus(1'b1, 1'b0, 1'b0, a, d, 1'($urandom), 16'($urandom));
            2: applyStimulus(1'b1, 1'($urandom), 1'b1, a | 16'h1, d, 1'($urandom), 16'($urandom));
            3: doAccess(1'b1, 1'b0, a, d, $urandom_range(0, 3), 16'($urandom));
            default: doAccess(1'($urandom), 1'b1, a, d, $urandom_range(0, 3), 16'($urandom));
         endcase
      end

      $display("[TB] access with no completion");
      for (int i = 0; i < 101; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 16'($urandom));
      end
      midCycleReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Absolute time bound so the bench can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "[TB] time limit");
   end

endmodule
